// File: rtl/cla_nibble_seq_if.sv
// Operand/result bundle for the nibble-serial adder/subtractor.
// The master side issues requests; the slave side (the adder) returns results.
interface cla_nibble_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, S, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, S, cout, ovf
  );
endinterface

// File: rtl/cla_nibble_seq.sv
// Nibble-serial WIDTH-bit adder/subtractor built around a single 4-bit
// carry-lookahead slice. Operands are consumed LSB nibble first, one nibble
// per clock, with the slice carry registered between steps. WIDTH must be a
// multiple of 4 and at least 8.

// 4-bit carry-lookahead slice: all carries are formed directly from the
// generate/propagate terms and the slice carry-in, no internal ripple.
module cla4_slice (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a_i ^ b_i;
  assign g = a_i & b_i;

  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_i);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_i);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sum
      assign s_o[gi] = p[gi] ^ c[gi];
    end
  endgenerate

  assign c_o = c[4];
endmodule

module cla_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cla_nibble_seq_if.slave      bus
);
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             msb_a_q, msb_a_d;
  logic             msb_b_q, msb_b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [3:0]       slice_s;
  logic             slice_c;
  logic             accept;
  logic             last_nib;

  // Only the low nibble of each shift register feeds the single slice.
  cla4_slice u_slice (
    .a_i (opa_q[3:0]),
    .b_i (opb_q[3:0]),
    .c_i (carry_q),
    .s_o (slice_s),
    .c_o (slice_c)
  );

  assign accept   = (state_q == IDLE) && bus.start;
  assign last_nib = (cnt_q == CW'(NIB - 1));

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: start is only looked at in IDLE, DONE always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_nib)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next state: capture on accept, shift one nibble per RUN cycle,
  // and publish the result only when the final nibble completes.
  always_comb begin
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    msb_a_d = msb_a_q;
    msb_b_d = msb_b_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (accept) begin
      // Subtraction is A + ~B + 1, so B is inverted up front and the +1
      // enters as the initial carry.
      opa_d   = bus.a;
      opb_d   = bus.sub ? ~bus.b : bus.b;
      carry_d = bus.sub ? 1'b1 : bus.cin;
      msb_a_d = bus.a[WIDTH-1];
      msb_b_d = opb_d[WIDTH-1];
      res_d   = '0;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      opa_d   = {4'b0000, opa_q[WIDTH-1:4]};
      opb_d   = {4'b0000, opb_q[WIDTH-1:4]};
      carry_d = slice_c;
      res_d   = {slice_s, res_q[WIDTH-1:4]};
      cnt_d   = cnt_q + CW'(1);
      if (last_nib) begin
        s_d    = res_d;
        cout_d = slice_c;
        // Overflow: both effective operands share a sign the result lacks.
        ovf_d  = (msb_a_q == msb_b_q) && (res_d[WIDTH-1] != msb_a_q);
      end
    end
  end

  // Datapath registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      msb_a_q <= 1'b0;
      msb_b_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      msb_a_q <= msb_a_d;
      msb_b_q <= msb_b_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.S    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_cla_nibble_seq.sv
// Bench for cla_nibble_seq (WIDTH=16): directed vector table, randomized
// operations against an arithmetic reference, and multi-cycle corner cases.
module tb_cla_nibble_seq;
  localparam int W = 16;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  cla_nibble_seq_if #(.WIDTH(W)) bus ();

  cla_nibble_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    int          mode;   // 0 plain, 1 extra start pulses, 2 inputs changed after start
    logic [15:0] exp_s;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range check for overflow.
  task automatic model(input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input logic sb, output logic [15:0] s, output logic c,
                       output logic o);
    logic [16:0] full;
    int r;
    int sa;
    int sbv;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    if (sb) begin
      full = 17'(a) + 17'(16'hFFFF - b) + 17'd1;
      r    = sa - sbv;
    end else begin
      full = 17'(a) + 17'(b) + 17'(ci);
      r    = sa + sbv + (ci ? 1 : 0);
    end
    s = full[15:0];
    c = full[16];
    o = (r > 32767) || (r < -32768);
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic sb, input int mode, input logic [15:0] es,
                        input logic ec, input logic eo, input string nm);
    int done_at;
    int done_cnt;
    int busy_cnt;
    logic [15:0] got_s;
    logic got_c;
    logic got_o;
    done_at  = 0;
    done_cnt = 0;
    busy_cnt = 0;
    got_s    = '0;
    got_c    = 1'b0;
    got_o    = 1'b0;
    @(negedge clk);
    bus.a     = a;
    bus.b     = b;
    bus.cin   = ci;
    bus.sub   = sb;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (mode == 2) begin
      bus.a   = 16'($urandom);
      bus.b   = 16'($urandom);
      bus.cin = ~ci;
      bus.sub = ~sb;
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = k;
          got_s   = bus.S;
          got_c   = bus.cout;
          got_o   = bus.ovf;
        end
      end
      if (mode == 1) bus.start = (k == 2 || k == 4);
    end
    bus.start = 1'b0;
    chk({nm, ".latency"}, done_at, 5);
    chk({nm, ".done_pulses"}, done_cnt, 1);
    chk({nm, ".busy_cycles"}, busy_cnt, 5);
    chk({nm, ".S"}, got_s, es);
    chk({nm, ".cout"}, got_c, ec);
    chk({nm, ".ovf"}, got_o, eo);
    chk({nm, ".S_hold"}, bus.S, es);
    $display("op %s a=%h b=%h cin=%0d sub=%0d -> S=%h cout=%0d ovf=%0d done_at=%0d",
             nm, a, b, ci, sb, got_s, got_c, got_o, done_at);
  endtask

  initial begin
    logic [15:0] ra, rb, es;
    logic rci, rsb, ec, eo;
    int d1, d2, cyc;

    total = 0;
    bad   = 0;

    vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 0, 16'h2233, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 0, 16'h0001, 1'b1, 1'b0};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 0, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 0, 16'h0002, 1'b1, 1'b0};
    vecs[5] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 16'h8000, 1'b0, 1'b1};
    vecs[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 0, 16'h7FFF, 1'b1, 1'b1};
    vecs[7] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 1, 16'h2233, 1'b0, 1'b0};
    vecs[8] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 2, 16'h0002, 1'b1, 1'b0};

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset.busy", bus.busy, 0);
    chk("reset.done", bus.done, 0);
    chk("reset.S", bus.S, 0);
    chk("reset.cout_ovf", {bus.cout, bus.ovf}, 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].mode,
             vecs[i].exp_s, vecs[i].exp_cout, vecs[i].exp_ovf, $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rci = 1'($urandom);
      rsb = 1'($urandom);
      if (i % 5 == 0) ra = 16'h8000 | 16'($urandom_range(0, 3));
      model(ra, rb, rci, rsb, es, ec, eo);
      run_op(ra, rb, rci, rsb, (i % 3 == 0) ? 2 : 0, es, ec, eo, $sformatf("rnd%0d", i));
    end

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    bus.a     = 16'h1234;
    bus.b     = 16'h0FFF;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrun.busy_before", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk("midrun.busy", bus.busy, 0);
    chk("midrun.done", bus.done, 0);
    chk("midrun.S", bus.S, 0);
    chk("midrun.cout_ovf", {bus.cout, bus.ovf}, 0);
    $display("op midrun_reset busy=%0d done=%0d S=%h", bus.busy, bus.done, bus.S);
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h0006, 16'h000A, 1'b1, 1'b0, 0, 16'h0011, 1'b0, 1'b0, "post_reset");

    // Start held high: re-triggers on every IDLE edge, one op per NIB+2 cycles.
    @(negedge clk);
    bus.a     = 16'h0001;
    bus.b     = 16'h0002;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;
    bus.start = 1'b1;
    d1  = 0;
    d2  = 0;
    cyc = 0;
    while (cyc < 20 && d2 == 0) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        if (d1 == 0) d1 = cyc;
        else         d2 = cyc;
      end
    end
    bus.start = 1'b0;
    chk("held.first_done", d1, 5);
    chk("held.spacing", d2 - d1, 6);
    chk("held.S", bus.S, 16'h0003);
    $display("op held_start first_done=%0d second_done=%0d S=%h", d1, d2, bus.S);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
